vb_wb_initiator: RTL and testbench
==================================

// Module: vb_wb_initiator
// PURPOSE
//  Wishbone classic initiator (bus master): the counterpart to the vb_wrapper Wishbone responder.
//  Converts a valid/ready command stream into single Wishbone read/write cycles and returns a response stream.
//  Lets on-chip logic (e.g. an IO-pin host bridge or self-test engine) drive the vb_wrapper slave port.
// PARAMETERS
//  AW               32   address width; adr_o is word aligned
//  DW               32   data width (byte lanes = DW/8)
//  TIMEOUT_CYCLES   256  BUS-state cycles without ack before abort (only with VB_WB_TIMEOUT_EN)
// PORTS
//  wb_clk_i     in   1      single clock; all logic on rising edge
//  wb_rst_ni    in   1      asynchronous, active-low reset
//  cmd_valid    in   1      command present
//  cmd_ready    out  1      command accepted when valid&&ready
//  cmd_we       in   1      1=write, 0=read
//  cmd_sel      in   DW/8   byte enables
//  cmd_addr     in   AW     byte address; bits [1:0] ignored
//  cmd_wdata    in   DW     write data
//  rsp_valid    out  1      response present
//  rsp_ready    in   1      response consumed when valid&&ready
//  rsp_rdata    out  DW     read data (0 for writes / aborted cycles)
//  rsp_err      out  1      1 = cycle aborted by timeout
//  wbm_cyc_o    out  1      Wishbone CYC
//  wbm_stb_o    out  1      Wishbone STB
//  wbm_we_o     out  1      Wishbone WE
//  wbm_sel_o    out  DW/8   Wishbone SEL
//  wbm_adr_o    out  AW     Wishbone ADR = {cmd_addr[AW-1:2],2'b00}
//  wbm_dat_o    out  DW     Wishbone write data
//  wbm_ack_i    in   1      Wishbone ACK from responder
//  wbm_dat_i    in   DW     Wishbone read data
// BEHAVIOUR
//  - Reset (async, wb_rst_ni=0): all outputs 0 except cmd_ready=0; state IDLE; a reset mid-cycle drops cyc/stb immediately.
//  - All outputs are registered. FSM: IDLE -> BUS -> RESP -> IDLE.
//  - IDLE: cmd_ready=1. On handshake latch we/sel/addr/wdata; next cycle cyc=stb=1, state BUS.
//  - BUS: cmd_ready=0; cyc/stb/we/sel/adr/dat held stable until ack sampled. On ack: cyc=stb=0 next
//    edge, rsp_rdata=we?0:wbm_dat_i, rsp_err=0, rsp_valid=1, state RESP. Earliest ack is first BUS cycle.
//  - RESP: rsp_valid held with stable data until rsp_ready; then rsp_valid=0, state IDLE (one bubble).
//    Minimum 3 cycles per transfer; at most one outstanding transfer.
//  - ack seen outside BUS is ignored. wbm_we_o/sel/adr/dat may retain last value when cyc=0.
//  - Timeout counter width = $clog2(TIMEOUT_CYCLES+1); cleared on entering BUS; saturates.
// CONFIGURATION
//  VB_WB_TIMEOUT_EN defined: in BUS, if counter reaches TIMEOUT_CYCLES-1 with no ack, drop cyc/stb,
//    rsp_err=1, rsp_rdata=0, go RESP. Ack and timeout in the same cycle: ack wins (normal response).
//  Undefined: no counter logic; BUS waits indefinitely for ack; rsp_err tied 0.
// STRUCTURE
//  Package vb_wb_pkg: FSM state encoding (IDLE/BUS/RESP), WB_AW/WB_DW defaults, SEL width function.
//  Sub-module vb_wb_timeout (clear/enable/expired counter), instantiated only under VB_WB_TIMEOUT_EN.
//  Top level: FSM, command latch, response register.
// TESTING
//  1 Write: cmd we=1 addr=0x3000_0004 sel=0xF wdata=0xCAFE_F00D, ack after 2 cycles -> one cyc/stb
//    pulse, adr_o=0x3000_0004, dat_o=0xCAFE_F00D held until ack; rsp_valid, rsp_err=0, rdata=0.
//  2 Read: addr=0x3000_0007 sel=0x3, ack on first BUS cycle with dat_i=0x1234_5678 -> adr_o=0x3000_0004,
//    rsp_rdata=0x1234_5678, cyc low the cycle after ack.
//  3 Backpressure: rsp_ready=0 for 5 cycles -> rsp_valid/rdata stable, cmd_ready=0, no new cyc.
//  4 Timeout (EN, TIMEOUT_CYCLES=8): no ack -> cyc drops after 8 BUS cycles, rsp_err=1, rdata=0;
//    ack on the 8th cycle instead -> rsp_err=0.
//  5 Reset mid-cycle: deassert wb_rst_ni during BUS -> cyc/stb/rsp_valid 0 asynchronously; after
//    release, cmd_ready=1 one cycle later and next command completes normally.
//  6 Back-to-back: 4 commands with cmd_valid held, zero-wait ack, rsp_ready=1 -> 4 responses in
//    order, one transfer per 3 cycles, stray ack in IDLE ignored.

Source files
------------

// File: rtl/vb_wb_pkg.sv
// Shared types and defaults for the vb_wb Wishbone initiator.
package vb_wb_pkg;

  localparam int WB_AW = 32;
  localparam int WB_DW = 32;
  localparam int WB_TIMEOUT_DEFAULT = 256;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } wb_state_e;

  function automatic int sel_width(input int dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/vb_wb_timeout.sv
// Saturating bus-cycle watchdog for the Wishbone initiator; expired_o flags
// the last BUS cycle allowed without an ack.
module vb_wb_timeout #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: clear has priority, then saturating increment while enabled
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = {CW{1'b0}};
    end else if (en_i && (cnt_q != CW'(TIMEOUT_CYCLES))) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= {CW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/vb_wb_initiator.sv
// Wishbone classic initiator: one command in, one single read/write cycle out,
// one response back. Optional ack timeout enabled by defining VB_WB_TIMEOUT_EN.
module vb_wb_initiator
  import vb_wb_pkg::*;
#(
  parameter int AW             = WB_AW,
  parameter int DW             = WB_DW,
  parameter int TIMEOUT_CYCLES = WB_TIMEOUT_DEFAULT
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_ni,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_we,
  input  logic [sel_width(DW)-1:0] cmd_sel,
  input  logic [AW-1:0]           cmd_addr,
  input  logic [DW-1:0]           cmd_wdata,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DW-1:0]           rsp_rdata,
  output logic                    rsp_err,
  output logic                    wbm_cyc_o,
  output logic                    wbm_stb_o,
  output logic                    wbm_we_o,
  output logic [sel_width(DW)-1:0] wbm_sel_o,
  output logic [AW-1:0]           wbm_adr_o,
  output logic [DW-1:0]           wbm_dat_o,
  input  logic                    wbm_ack_i,
  input  logic [DW-1:0]           wbm_dat_i
);

  localparam int SW = sel_width(DW);

  wb_state_e      state_q;
  logic           cmd_ready_q;
  logic           rsp_valid_q;
  logic [DW-1:0]  rsp_rdata_q;
  logic           rsp_err_q;
  logic           cyc_q;
  logic           stb_q;
  logic           we_q;
  logic [SW-1:0]  sel_q;
  logic [AW-1:0]  adr_q;
  logic [DW-1:0]  dat_q;
  logic           cmd_fire_s;
  logic           unused_addr_s;

  // cmd_ready_q is only ever high in IDLE, so it alone qualifies the handshake
  assign cmd_fire_s    = cmd_valid && cmd_ready_q;
  assign unused_addr_s = ^cmd_addr[1:0];

`ifdef VB_WB_TIMEOUT_EN
  logic expired_s;
  logic bus_s;

  assign bus_s = (state_q == ST_BUS);

  vb_wb_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i     (wb_clk_i),
    .rst_ni    (wb_rst_ni),
    .clr_i     (cmd_fire_s),
    .en_i      (bus_s),
    .expired_o (expired_s)
  );
`else
  logic [31:0] unused_timeout_s;
  assign unused_timeout_s = 32'(TIMEOUT_CYCLES);
`endif

  // Transfer FSM with registered bus and response outputs
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= {DW{1'b0}};
      rsp_err_q   <= 1'b0;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= {SW{1'b0}};
      adr_q       <= {AW{1'b0}};
      dat_q       <= {DW{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_fire_s) begin
            cmd_ready_q <= 1'b0;
            cyc_q       <= 1'b1;
            stb_q       <= 1'b1;
            we_q        <= cmd_we;
            sel_q       <= cmd_sel;
            adr_q       <= {cmd_addr[AW-1:2], 2'b00};
            dat_q       <= cmd_wdata;
            state_q     <= ST_BUS;
          end else begin
            cmd_ready_q <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        ST_BUS: begin
          if (wbm_ack_i) begin
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= we_q ? {DW{1'b0}} : wbm_dat_i;
            rsp_err_q   <= 1'b0;
            state_q     <= ST_RESP;
          end
`ifdef VB_WB_TIMEOUT_EN
          else if (expired_s) begin
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= {DW{1'b0}};
            rsp_err_q   <= 1'b1;
            state_q     <= ST_RESP;
          end
`endif
          else begin
            state_q <= ST_BUS;
          end
        end
        ST_RESP: begin
          // Going straight to a ready IDLE keeps the transfer rate at one per 3 cycles
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= ST_IDLE;
          end else begin
            state_q <= ST_RESP;
          end
        end
        default: begin
          cyc_q       <= 1'b0;
          stb_q       <= 1'b0;
          rsp_valid_q <= 1'b0;
          cmd_ready_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = stb_q;
  assign wbm_we_o  = we_q;
  assign wbm_sel_o = sel_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;

endmodule

// File: tb/tb_vb_wb_initiator.sv
// Directed bench for vb_wb_initiator; the timeout sequence runs only when
// VB_WB_TIMEOUT_EN is defined (TIMEOUT_CYCLES = 8).
module tb_vb_wb_initiator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [3:0]  cmd_sel;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        cyc, stb, we_o, ack;
  logic [3:0]  sel_o;
  logic [31:0] adr_o, dat_o, dat_i;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    int          delay;
    logic [31:0] rdat;
    int          bp;
    logic [31:0] exp_adr;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[6];

  always #5 clk = ~clk;

  vb_wb_initiator #(.AW(32), .DW(32), .TIMEOUT_CYCLES(8)) dut (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_we    (cmd_we),
    .cmd_sel   (cmd_sel),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .wbm_cyc_o (cyc),
    .wbm_stb_o (stb),
    .wbm_we_o  (we_o),
    .wbm_sel_o (sel_o),
    .wbm_adr_o (adr_o),
    .wbm_dat_o (dat_o),
    .wbm_ack_i (ack),
    .wbm_dat_i (dat_i)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where the response has just been consumed.
  task automatic run_vec(input vec_t v);
    int n;
    rsp_ready = 1'b1;
    cmd_valid = 1'b1;
    cmd_we    = v.we;
    cmd_sel   = v.sel;
    cmd_addr  = v.addr;
    cmd_wdata = v.wdata;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("cmd_ready_wait", 64'(n < 20), 64'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int c = 0; c <= v.delay; c++) begin
      check("bus_ctrl", {58'd0, cyc, stb, cmd_ready, we_o, 2'b00}, {58'd0, 1'b1, 1'b1, 1'b0, v.we, 2'b00});
      check("bus_sel_adr", {28'd0, sel_o, adr_o}, {28'd0, v.sel, v.exp_adr});
      check("bus_dat", 64'(dat_o), 64'(v.wdata));
      if (c == v.delay) begin
        ack   = 1'b1;
        dat_i = v.rdat;
      end
      @(negedge clk);
    end
    ack   = 1'b0;
    dat_i = 32'h0;
    check("rsp_first", {29'd0, cyc, rsp_valid, rsp_err, rsp_rdata}, {29'd0, 1'b0, 1'b1, 1'b0, v.exp_rdata});
    if (v.bp > 0) begin
      rsp_ready = 1'b0;
      cmd_valid = 1'b1;
    end
    for (int i = 1; i <= v.bp; i++) begin
      @(negedge clk);
      check("rsp_hold", {29'd0, cyc, rsp_valid, cmd_ready, rsp_rdata}, {29'd0, 1'b0, 1'b1, 1'b0, v.exp_rdata});
      if (i == v.bp) rsp_ready = 1'b1;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    check("rsp_done", {61'd0, rsp_valid, cmd_ready, cyc}, {61'd0, 1'b0, 1'b1, 1'b0});
  endtask

  function automatic logic [31:0] pat(input int k);
    return 32'hB2B0_0000 | 32'(k);
  endfunction

  initial begin
    int   n, k_cmd, k_cyc, k_rsp, last_rsp;
    logic pending;
    vec_t v;

    //            we    addr          sel    wdata         dly rdat          bp exp_adr       exp_rdata
    vecs[0] = '{1'b1, 32'h3000_0004, 4'hF, 32'hCAFE_F00D, 2, 32'hDEAD_BEEF, 0, 32'h3000_0004, 32'h0000_0000};
    vecs[1] = '{1'b0, 32'h3000_0007, 4'h3, 32'h1111_2222, 0, 32'h1234_5678, 0, 32'h3000_0004, 32'h1234_5678};
    vecs[2] = '{1'b0, 32'h2000_0008, 4'hF, 32'h0000_0000, 1, 32'h5555_AAAA, 5, 32'h2000_0008, 32'h5555_AAAA};
    vecs[3] = '{1'b0, 32'h0000_0002, 4'h1, 32'h0F0F_0F0F, 1, 32'hA5A5_0001, 0, 32'h0000_0000, 32'hA5A5_0001};
    vecs[4] = '{1'b1, 32'hFFFF_FFFF, 4'h8, 32'h0000_0001, 3, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFC, 32'h0000_0000};
    vecs[5] = '{1'b0, 32'h8000_0010, 4'hC, 32'h7777_7777, 5, 32'h0BAD_CAFE, 0, 32'h8000_0010, 32'h0BAD_CAFE};

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_sel = 4'h0;
    cmd_addr = 32'h0; cmd_wdata = 32'h0; rsp_ready = 1'b1; ack = 1'b0; dat_i = 32'h0;

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_ctrl", {57'd0, cmd_ready, rsp_valid, rsp_err, cyc, stb, we_o, 1'b0}, 64'd0);
    check("reset_data", {rsp_rdata, adr_o}, 64'd0);
    check("reset_dat_sel", {28'd0, sel_o, dat_o}, 64'd0);
    rst_n = 1'b1;
    check("ready_after_release", 64'(cmd_ready), 64'd0);
    @(negedge clk);
    check("ready_one_cycle", 64'(cmd_ready), 64'd1);

    // Table-driven single transfers (write, read, backpressure, address alignment)
    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

`ifdef VB_WB_TIMEOUT_EN
    // No ack: cycle aborts after exactly 8 BUS cycles
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_sel = 4'hF; cmd_addr = 32'h0000_0040;
    n = 0;
    while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (cyc && n < 20) begin n++; @(negedge clk); end
    check("timeout_cycles", 64'(n), 64'd8);
    check("timeout_rsp", {29'd0, rsp_valid, rsp_err, 1'b0, rsp_rdata}, {29'd0, 1'b1, 1'b1, 1'b0, 32'h0});
    @(negedge clk);
    check("timeout_consumed", {62'd0, rsp_valid, cmd_ready}, {62'd0, 1'b0, 1'b1});
    // Ack on the 8th cycle wins over the timeout
    v = '{1'b0, 32'h0000_0044, 4'hF, 32'h0, 7, 32'h0000_0077, 0, 32'h0000_0044, 32'h0000_0077};
    run_vec(v);
`endif

    // Reset in the middle of a BUS cycle
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_sel = 4'hF; cmd_addr = 32'h0000_0100; cmd_wdata = 32'h5A5A_5A5A;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("pre_reset_bus", 64'(cyc), 64'd1);
    #2 rst_n = 1'b0;
    #1 check("async_reset", {60'd0, cyc, stb, rsp_valid, cmd_ready}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check("ready_after_midreset", 64'(cmd_ready), 64'd0);
    @(negedge clk);
    check("ready_one_cycle_mid", 64'(cmd_ready), 64'd1);
    run_vec(vecs[1]);

    // Back-to-back reads, ack held high (including while IDLE/RESP)
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_sel = 4'hF; cmd_addr = 32'h0000_0200;
    ack = 1'b1; rsp_ready = 1'b1;
    k_cmd = 0; k_cyc = 0; k_rsp = 0; last_rsp = -1;
    pending = cmd_ready;
    for (int t = 0; t < 40 && k_rsp < 4; t++) begin
      @(negedge clk);
      if (pending) begin
        k_cmd++;
        if (k_cmd == 4) cmd_valid = 1'b0;
        else cmd_addr = 32'h0000_0200 + 32'(4 * k_cmd);
      end
      if (cyc) begin
        check("b2b_adr", 64'(adr_o), 64'(32'h0000_0200 + 32'(4 * k_cyc)));
        dat_i = pat(k_cyc);
        k_cyc++;
      end
      if (rsp_valid) begin
        check("b2b_rdata", 64'(rsp_rdata), 64'(pat(k_rsp)));
        if (k_rsp > 0) check("b2b_period", 64'(t - last_rsp), 64'd3);
        last_rsp = t;
        k_rsp++;
      end
      pending = cmd_valid && cmd_ready;
    end
    check("b2b_counts", {32'(k_cyc), 32'(k_rsp)}, {32'd4, 32'd4});
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stray_ack_idle", {61'd0, cyc, rsp_valid, cmd_ready}, {61'd0, 1'b0, 1'b0, 1'b1});
    end
    ack = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected finish before 200000");
    $fatal(1);
  end

endmodule
